// File: rtl/reorder_buffer.sv
// Circular reorder buffer sitting between dispatch and retire.
// Each dispatched instruction gets an entry and a tag. Execution writeback marks
// the entry complete. Completed entries retire strictly in program order from
// the head. A flush discards every entry.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   alloc_valid/_dest/_has_dest dispatch request and destination info
//   alloc_ready, alloc_tag      accept indication and tag (tail) for this cycle
//   wb_valid/_tag/_value        execution result for an entry
//   commit_valid/_dest/_has_dest/_value  head entry retiring this cycle
//   flush                       discard all entries
//   rob_full, rob_empty, rob_count       occupancy status (from registered count)
module reorder_buffer #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest,
   input  logic              alloc_has_dest,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_value,
   output logic              commit_valid,
   output logic [REG_W-1:0]  commit_dest,
   output logic              commit_has_dest,
   output logic [DATA_W-1:0] commit_value,
   input  logic              flush,
   output logic              rob_full,
   output logic              rob_empty,
   output logic [TAG_W:0]    rob_count
);

   localparam int unsigned CNT_W = TAG_W + 1;

   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              valid_q    [DEPTH];
   logic              valid_d    [DEPTH];
   logic              done_q     [DEPTH];
   logic              done_d     [DEPTH];
   logic [REG_W-1:0]  dest_q     [DEPTH];
   logic [REG_W-1:0]  dest_d     [DEPTH];
   logic              has_dest_q [DEPTH];
   logic              has_dest_d [DEPTH];
   logic [DATA_W-1:0] value_q    [DEPTH];
   logic [DATA_W-1:0] value_d    [DEPTH];

   logic              alloc_fire;

   // Status and handshake; full/empty come from the registered count only.
   always_comb begin
      rob_full        = (count_q == CNT_W'(DEPTH));
      rob_empty       = (count_q == '0);
      rob_count       = count_q;
      alloc_ready     = !rob_full && !flush;
      alloc_tag       = tail_q;
      alloc_fire      = alloc_valid && alloc_ready;
      commit_valid    = valid_q[head_q] && done_q[head_q] && !flush;
      commit_dest     = dest_q[head_q];
      commit_has_dest = has_dest_q[head_q];
      commit_value    = value_q[head_q];
   end

   // Next state: writeback, then commit, then allocate (allocate wins at tail).
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         valid_d[i]    = valid_q[i];
         done_d[i]     = done_q[i];
         dest_d[i]     = dest_q[i];
         has_dest_d[i] = has_dest_q[i];
         value_d[i]    = value_q[i];
      end

      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_d[i] = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wb_valid && valid_q[wb_tag]) begin
            done_d[wb_tag]  = 1'b1;
            value_d[wb_tag] = wb_value;
         end
         if (commit_valid) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_W'(1);
         end
         if (alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            done_d[tail_q]     = 1'b0;
            dest_d[tail_q]     = alloc_dest;
            has_dest_d[tail_q] = alloc_has_dest;
            tail_d             = tail_q + TAG_W'(1);
         end
         count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_valid);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i]    <= 1'b0;
            done_q[i]     <= 1'b0;
            dest_q[i]     <= '0;
            has_dest_q[i] <= 1'b0;
            value_q[i]    <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i]    <= valid_d[i];
            done_q[i]     <= done_d[i];
            dest_q[i]     <= dest_d[i];
            has_dest_q[i] <= has_dest_d[i];
            value_q[i]    <= value_d[i];
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the in-flight instructions.
module tb_reorder_buffer;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int TAG_W  = 3;

   logic              clk;
   logic              reset;
   logic              alloc_valid;
   logic [REG_W-1:0]  alloc_dest;
   logic              alloc_has_dest;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag;
   logic              wb_valid;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_value;
   logic              commit_valid;
   logic [REG_W-1:0]  commit_dest;
   logic              commit_has_dest;
   logic [DATA_W-1:0] commit_value;
   logic              flush;
   logic              rob_full;
   logic              rob_empty;
   logic [TAG_W:0]    rob_count;

   reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_has_dest(alloc_has_dest),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .commit_valid(commit_valid), .commit_dest(commit_dest),
      .commit_has_dest(commit_has_dest), .commit_value(commit_value),
      .flush(flush), .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: in-flight instructions in program order, plus the next tag to hand out.
   typedef struct {
      int          tag;
      logic [4:0]  dest;
      logic        hd;
      logic        done;
      logic [31:0] value;
   } ent_t;

   ent_t mq[$];
   int   tail_m;
   int   n_vec;
   int   n_err;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int  cnt;
      logic cv;
      cnt = mq.size();
      cv  = (cnt > 0) && mq[0].done && !flush;
      check_eq("rob_count", 64'(rob_count), 64'(cnt));
      check_eq("rob_full", 64'(rob_full), 64'(cnt == DEPTH));
      check_eq("rob_empty", 64'(rob_empty), 64'(cnt == 0));
      check_eq("alloc_ready", 64'(alloc_ready), 64'((cnt < DEPTH) && !flush));
      check_eq("alloc_tag", 64'(alloc_tag), 64'(tail_m));
      check_eq("commit_valid", 64'(commit_valid), 64'(cv));
      if (cv) begin
         check_eq("commit_dest", 64'(commit_dest), 64'(mq[0].dest));
         check_eq("commit_has_dest", 64'(commit_has_dest), 64'(mq[0].hd));
         check_eq("commit_value", 64'(commit_value), 64'(mq[0].value));
      end
   endtask

   // One clock: drive, check outputs before the edge, clock, advance the model.
   task automatic cycle(input logic av, input logic [4:0] dst, input logic hd,
                        input logic wv, input logic [2:0] wt, input logic [31:0] wval,
                        input logic fl);
      logic cv, acc;
      ent_t e;
      alloc_valid = av; alloc_dest = dst; alloc_has_dest = hd;
      wb_valid = wv; wb_tag = wt; wb_value = wval; flush = fl;
      #1;
      check_outputs();
      cv  = (mq.size() > 0) && mq[0].done && !fl;
      acc = av && (mq.size() < DEPTH) && !fl;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         tail_m = 0;
      end else begin
         if (wv) begin
            foreach (mq[i]) begin
               if (mq[i].tag == int'(wt)) begin
                  mq[i].done  = 1'b1;
                  mq[i].value = wval;
               end
            end
         end
         if (cv) void'(mq.pop_front());
         if (acc) begin
            e.tag = tail_m; e.dest = dst; e.hd = hd; e.done = 1'b0; e.value = '0;
            mq.push_back(e);
            tail_m = (tail_m + 1) % DEPTH;
         end
      end
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
   endtask

   task automatic alloc(input logic [4:0] dst);
      cycle(1'b1, dst, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
   endtask

   task automatic wb(input logic [2:0] t, input logic [31:0] v);
      cycle(1'b0, 5'd0, 1'b0, 1'b1, t, v, 1'b0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; tail_m = 0;
      reset = 1'b1;
      alloc_valid = 0; alloc_dest = 0; alloc_has_dest = 0;
      wb_valid = 0; wb_tag = 0; wb_value = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b0;
      @(posedge clk); #1;

      // Mid-cycle reset with three valid entries clears state without a clock edge.
      alloc(5'd1); alloc(5'd2); alloc(5'd3);
      wb(3'd0, 32'h11);
      reset = 1'b1;
      #1;
      mq.delete(); tail_m = 0;
      check_eq("rst_async_empty", 64'(rob_empty), 64'd1);
      check_eq("rst_async_count", 64'(rob_count), 64'd0);
      check_eq("rst_async_cvalid", 64'(commit_valid), 64'd0);
      check_eq("rst_async_tag", 64'(alloc_tag), 64'd0);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Fill to full, then a refused ninth allocate.
      for (int i = 0; i < DEPTH; i++) alloc(5'(i + 4));
      check_eq("fill_full", 64'(rob_full), 64'd1);
      check_eq("fill_ready", 64'(alloc_ready), 64'd0);
      alloc(5'd31);
      check_eq("fill_count9", 64'(rob_count), 64'd8);

      // Full with head done: commit happens, allocate refused, slot reused next cycle.
      wb(3'd0, 32'h5A5A);
      cycle(1'b1, 5'd9, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
      check_eq("full_commit_count", 64'(rob_count), 64'd7);
      alloc(5'd10);
      check_eq("full_realloc_count", 64'(rob_count), 64'd8);

      // Out-of-order writeback, in-order commit.
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
      alloc(5'd1); alloc(5'd2); alloc(5'd3);
      wb(3'd2, 32'hC);
      wb(3'd0, 32'hA);
      #0 check_eq("ooo_first_commit", 64'(commit_value), 64'hA);
      wb(3'd1, 32'hB);
      idle(); idle(); idle();
      check_eq("ooo_drained", 64'(rob_empty), 64'd1);

      // Steady occupancy of three across pointer wrap-around.
      alloc(5'd20); alloc(5'd21); alloc(5'd22);
      wb(3'(mq[0].tag), $urandom);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 5'($urandom), 1'($urandom), 1'b1, 3'(mq[1].tag), $urandom, 1'b0);
         check_eq("wrap_count", 64'(rob_count), 64'd3);
      end

      // Flush wins over allocate, writeback and a ready commit.
      cycle(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
      alloc(5'd7); alloc(5'd8);
      wb(3'd0, 32'h77);
      cycle(1'b1, 5'd9, 1'b1, 1'b1, 3'd0, 32'hDEAD, 1'b1);
      check_eq("flush_empty", 64'(rob_empty), 64'd1);
      check_eq("flush_tag0", 64'(alloc_tag), 64'd0);
      alloc(5'd12);
      idle();
      check_eq("flush_stale_wb", 64'(commit_valid), 64'd0);
      wb(3'd0, 32'h1234);
      idle();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic       av, wv, fl;
         logic [2:0] wt;
         av = ($urandom_range(0, 9) < 7);
         wv = ($urandom_range(0, 9) < 6);
         fl = ($urandom_range(0, 49) == 0);
         if (mq.size() > 0 && $urandom_range(0, 4) != 0)
            wt = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
         else
            wt = 3'($urandom);
         cycle(av, 5'($urandom), 1'($urandom), wv, wt, $urandom, fl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
